// File: rtl/render_sequencer.sv
// Selects which renderer drives the shared RGB pins; the debounced button or an
// optional frame timer advances the selection, applied only at vertical-blank start.
module render_sequencer #(
  parameter int unsigned V_RES       = 480,
  parameter int unsigned N_MODES     = 4,
  parameter int unsigned DB_CYCLES   = 120000,
  parameter int unsigned AUTO_FRAMES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [9:0]                 sx,
  input  logic [9:0]                 sy,
  input  logic                       de,
  input  logic                       btn,
  input  logic [6*N_MODES-1:0]       rgb_in,
  output logic [5:0]                 rgb,
  output logic [$clog2(N_MODES)-1:0] mode,
  output logic                       frame_tick,
  output logic                       mode_changed,
  output logic                       btn_level
);
  localparam int unsigned MODE_W = $clog2(N_MODES);
  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned AUTO_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  typedef enum logic [1:0] {REL, PRESS_WAIT, PRS, REL_WAIT} db_state_t;

  db_state_t         db_state;
  logic [DB_W-1:0]   db_cnt;
  logic              btn_m;
  logic              btn_s;
  logic              pending;
  logic [AUTO_W-1:0] auto_cnt;

  logic       db_done_c;
  logic       press_c;
  logic       tick_c;
  logic       expire_c;
  logic       advance_c;
  logic [5:0] sel_c;

  // The stable-sample count completes on the DB_CYCLES-th consecutive sample.
  assign db_done_c = (32'(db_cnt) + 32'd1) >= (DB_CYCLES - 32'd1);
  assign press_c   = (db_state == PRESS_WAIT) && btn_s && db_done_c;
  assign tick_c    = (sx == 10'd0) && (sy == 10'(V_RES));
  assign expire_c  = (AUTO_FRAMES != 0) && (32'(auto_cnt) == (AUTO_FRAMES - 32'd1));
  assign advance_c = tick_c && (pending || expire_c);

  // Renderer field for the current mode; unused encodings select black.
  always_comb begin
    sel_c = 6'd0;
    for (int unsigned k = 0; k < N_MODES; k++) begin
      if (32'(mode) == k) sel_c = rgb_in[6*k +: 6];
    end
  end

  // Button synchronizer and debounce FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_m     <= 1'b0;
      btn_s     <= 1'b0;
      db_state  <= REL;
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      case (db_state)
        REL: begin
          if (btn_s) begin
            db_state <= PRESS_WAIT;
            db_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            db_state <= REL;
          end else if (db_done_c) begin
            db_state  <= PRS;
            btn_level <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        PRS: begin
          if (!btn_s) begin
            db_state <= REL_WAIT;
            db_cnt   <= '0;
          end
        end
        REL_WAIT: begin
          if (btn_s) begin
            db_state <= PRS;
          end else if (db_done_c) begin
            db_state  <= REL;
            btn_level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: db_state <= REL;
      endcase
    end
  end

  // Frame-synchronous mode update and registered pixel mux.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb          <= 6'd0;
      mode         <= '0;
      frame_tick   <= 1'b0;
      mode_changed <= 1'b0;
      pending      <= 1'b0;
      auto_cnt     <= '0;
    end else begin
      rgb          <= de ? sel_c : 6'd0;
      frame_tick   <= tick_c;
      mode_changed <= advance_c;
      if (advance_c) begin
        mode     <= (32'(mode) == (N_MODES - 32'd1)) ? '0 : mode + MODE_W'(1);
        auto_cnt <= '0;
      end else if (tick_c && (AUTO_FRAMES != 0)) begin
        auto_cnt <= auto_cnt + AUTO_W'(1);
      end
      // A press coinciding with the tick survives into the next frame.
      if (press_c) begin
        pending <= 1'b1;
      end else if (advance_c) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_render_sequencer.sv
// Scoreboard bench for render_sequencer on a shrunken VGA raster with random button,
// pixel and reset stimulus checked against a run-length / frame-count reference model.
module tb_render_sequencer;
  localparam int unsigned V_RES       = 6;
  localparam int unsigned N_MODES     = 4;
  localparam int unsigned DB_CYCLES   = 4;
  localparam int unsigned AUTO_FRAMES = 3;
  localparam int unsigned H_ACT       = 10;
  localparam int unsigned H_TOT       = 16;
  localparam int unsigned V_TOT       = 9;
  localparam int unsigned FRAME       = H_TOT * V_TOT;
  localparam int unsigned MODE_W      = $clog2(N_MODES);
  localparam int unsigned PIX_W       = 6 * N_MODES;

  typedef struct packed {
    logic [5:0]        rgb;
    logic [MODE_W-1:0] mode;
    logic              tick;
    logic              changed;
    logic              level;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        sx = '0;
  logic [9:0]        sy = '0;
  logic              de = 1'b0;
  logic              btn = 1'b0;
  logic [PIX_W-1:0]  rgb_in = '0;
  logic [5:0]        rgb;
  logic [MODE_W-1:0] mode;
  logic              frame_tick;
  logic              mode_changed;
  logic              btn_level;

  always #5 clk = ~clk;

  render_sequencer #(
    .V_RES(V_RES), .N_MODES(N_MODES), .DB_CYCLES(DB_CYCLES), .AUTO_FRAMES(AUTO_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy), .de(de), .btn(btn), .rgb_in(rgb_in),
    .rgb(rgb), .mode(mode), .frame_tick(frame_tick), .mode_changed(mode_changed),
    .btn_level(btn_level)
  );

  obs_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state: raw button history, debounced level with run length,
  // pending request, frames since last advance, selected source.
  bit          m_s1, m_s2, m_level, m_pending;
  int unsigned m_run, m_auto, m_mode;
  int unsigned hx = 0, vy = 0;

  task automatic model_edge();
    obs_t e;
    bit   tick, press;
    e = '0;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_pending = 0;
      m_run = 0; m_auto = 0; m_mode = 0;
    end else begin
      e.rgb = de ? 6'(rgb_in >> (6 * m_mode)) : 6'd0;
      tick  = (sx == 10'd0) && (sy == 10'(V_RES));
      press = 0;
      if (m_s2 != m_level) begin
        m_run++;
        if (m_run == DB_CYCLES) begin
          m_level = m_s2;
          m_run   = 0;
          press   = m_level;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn;
      if (tick) begin
        if (m_pending || (AUTO_FRAMES != 0 && m_auto + 1 == AUTO_FRAMES)) begin
          m_mode    = (m_mode + 1) % N_MODES;
          m_pending = 0;
          m_auto    = 0;
          e.changed = 1'b1;
        end else begin
          m_auto++;
        end
      end
      if (press) m_pending = 1;
      e.tick  = tick;
      e.mode  = MODE_W'(m_mode);
      e.level = m_level;
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs from the bench raster and record the expected response.
  task automatic step(input bit r, input bit b, input logic [PIX_W-1:0] pix);
    @(negedge clk);
    rst_n  = r;
    btn    = b;
    rgb_in = pix;
    sx     = 10'(hx);
    sy     = 10'(vy);
    de     = (hx < H_ACT) && (vy < V_RES);
    model_edge();
    if (hx == H_TOT - 1) begin
      hx = 0;
      vy = (vy == V_TOT - 1) ? 0 : vy + 1;
    end else begin
      hx++;
    end
  endtask

  function automatic logic [PIX_W-1:0] rnd_pix();
    return PIX_W'($urandom);
  endfunction

  function automatic int unsigned dist_to_tick();
    return (V_RES * H_TOT + FRAME - (vy * H_TOT + hx)) % FRAME;
  endfunction

  task automatic idle_until(input int unsigned d);
    for (int unsigned i = 0; i < FRAME && dist_to_tick() != d; i++) step(1, 0, rnd_pix());
  endtask

  // Monitor: output is presented every cycle; compare against the scoreboard head.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{rgb: rgb, mode: mode, tick: frame_tick, changed: mode_changed, level: btn_level};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got rgb=%h mode=%0d tick=%b chg=%b lvl=%b want rgb=%h mode=%0d tick=%b chg=%b lvl=%b",
                   $time, a.rgb, a.mode, a.tick, a.changed, a.level,
                   e.rgb, e.mode, e.tick, e.changed, e.level);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PIX_W-1:0] wrap_pix;
    logic [PIX_W-1:0] white;
    bit               lvl;
    int unsigned      dur;
    wrap_pix = {6'h30, 6'h0C, 6'h03, 6'h01};
    white    = {N_MODES{6'h3F}};

    // Reset held with everything active, then release into full white.
    repeat (3) step(0, 1, white);
    repeat (20) step(1, 0, white);

    // Short glitch then a genuine press.
    repeat (3) step(1, 1, white);
    repeat (20) step(1, 0, white);
    repeat (8) step(1, 1, wrap_pix);
    repeat (2 * FRAME) step(1, 0, wrap_pix);

    // One press per frame: walk through every source and wrap.
    for (int i = 0; i < 4; i++) begin
      idle_until(FRAME - 20);
      repeat (10) step(1, 1, wrap_pix);
      repeat (20) step(1, 0, wrap_pix);
    end

    // Slide the press event across the frame boundary.
    for (int unsigned d = 2; d <= 9; d++) begin
      idle_until(d);
      repeat (8) step(1, 1, rnd_pix());
      repeat (FRAME / 2) step(1, 0, rnd_pix());
    end

    // Press mid-frame, start another, then reset while it is still being debounced.
    idle_until(FRAME - 30);
    repeat (8) step(1, 1, rnd_pix());
    repeat (6) step(1, 0, rnd_pix());
    repeat (4) step(1, 1, rnd_pix());
    repeat (2) step(0, 1, rnd_pix());
    repeat (2 * FRAME) step(1, 0, rnd_pix());

    // Random button activity, pixels and occasional resets.
    lvl = 0;
    for (int i = 0; i < 900; i++) begin
      lvl = ~lvl;
      dur = $urandom_range(1, 12);
      for (int unsigned j = 0; j < dur; j++) begin
        step(($urandom_range(0, 1999) != 0), lvl, rnd_pix());
      end
    end
    repeat (3 * FRAME) step(1, 0, rnd_pix());

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/render_sequencer.md
Name: render_sequencer

Overview:
- Sits between the VGA timing generator and the pixel output pins.
- Owns the single 6-bit RGB output and shares it between up to N_MODES renderers.
- Debounces the user push-button and advances the active renderer on each press, or optionally after a fixed number of frames.
- Selection changes only at vertical-blank start, so a frame never tears between renderers.

Parameters:
- V_RES, 480, active lines; the frame boundary is detected at sy == V_RES.
- N_MODES, 4, number of renderer sources on rgb_in (2..8).
- DB_CYCLES, 120000, clk cycles the synchronized button must be stable before a press or release is accepted (10 ms at 12 MHz).
- AUTO_FRAMES, 0, frames between automatic mode advances; 0 disables auto-advance.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sx  in  10  screen x coordinate from the VGA driver.
- sy  in  10  screen y coordinate from the VGA driver.
- de  in  1  active-display enable from the VGA driver.
- btn  in  1  raw button, active-high, asynchronous to clk.
- rgb_in  in  6*N_MODES  packed renderer outputs; source k occupies bits [6k+5:6k].
- rgb  out  6  registered pixel output.
- mode  out  clog2(N_MODES)  currently displayed source index.
- frame_tick  out  1  one-cycle pulse at each vertical-blank start.
- mode_changed  out  1  one-cycle pulse, coincident with frame_tick, when mode advanced.
- btn_level  out  1  debounced button level.

Behaviour:
- Reset (rst_n low at a clk edge) forces: rgb=0, mode=0, frame_tick=0, mode_changed=0, btn_level=0, pending=0, auto counter=0, debounce FSM=REL, synchronizer flops=0. Reset mid-frame or mid-debounce discards all progress.
- Synchronizer: btn passes through 2 flops; btn_s is the second flop. All debounce logic uses btn_s only.
- Debounce FSM (counter db_cnt, width clog2(DB_CYCLES+1)):
  - REL: btn_level=0. btn_s=1 -> PRESS_WAIT, db_cnt=0.
  - PRESS_WAIT: btn_s=0 -> REL. Otherwise db_cnt++. When db_cnt reaches DB_CYCLES-1 -> PRS, btn_level=1, one-cycle press event.
  - PRS: btn_level=1. btn_s=0 -> REL_WAIT, db_cnt=0.
  - REL_WAIT: btn_s=1 -> PRS. Otherwise count to DB_CYCLES-1, then -> REL, btn_level=0.
  - Glitches shorter than DB_CYCLES produce no event.
- Press event sets pending=1. Multiple presses within one frame collapse to a single pending advance.
- Frame boundary: when sx==0 && sy==V_RES is sampled, frame_tick=1 on the next cycle, for exactly one cycle.
- Update at frame_tick. The advance condition is pending OR (AUTO_FRAMES!=0 AND auto_cnt==AUTO_FRAMES-1).
  - Advance: mode <= (mode==N_MODES-1) ? 0 : mode+1; mode_changed=1; pending=0; auto_cnt=0.
  - No advance: auto_cnt++ (held at 0 when AUTO_FRAMES==0).
  - Press and auto-expiry on the same tick: advance exactly once.
  - A press event in the same cycle as frame_tick is not lost; it becomes pending for the next frame.
- Output mux (latency 1): rgb <= de ? rgb_in[6*mode +: 6] : 6'b0. The de/sx/sy-to-rgb alignment is one clk; the VGA driver's sync outputs are expected to carry matching delay.
- mode is stable for all active pixels of a frame and changes only on the frame_tick cycle.

Test Plan:
- Reset: DB_CYCLES=4. Hold rst_n=0 for 3 clks with btn=1, de=1, rgb_in all 6'h3F -> rgb=0, mode=0, btn_level=0 throughout. Release reset -> rgb=6'h3F from the next de cycle.
- Debounce: DB_CYCLES=4, btn high for 3 clks then low -> btn_level stays 0, mode stays 0. btn high for 8 clks -> btn_level=1 exactly 2+4 clks after the rise. At the next sy==480, sx==0 the bench sees frame_tick and mode_changed together, and mode=1.
- Wrap: N_MODES=4, one debounced press per frame over 4 frames -> mode sequence 1,2,3,0. rgb_in={6'h30,6'h0C,6'h03,6'h01} -> rgb follows the selected field, and is 0 when de=0.
- Auto plus collision: AUTO_FRAMES=3, no press -> mode advances every 3rd frame_tick. A press pending on the same tick as expiry -> a single advance; the next auto advance comes 3 frames later.
- Mid-frame press: press accepted at sy=100 -> mode is unchanged until the frame_tick after sy=480, and no pixel of the current frame changes source.
- Reset mid-operation: assert rst_n=0 during PRESS_WAIT with pending=1 and mode=2 -> mode=0, pending cleared, and no advance at the following frame_tick.
